// File: rtl/camera_pkg.sv
// Shared camera-path definitions: packing geometry, frame bound default and packer states.
package camera_pkg;

  localparam int unsigned PIX_PER_WORD    = 32;
  localparam int unsigned IDX_W           = $clog2(PIX_PER_WORD);
  localparam int unsigned HALF_W          = 16;
  localparam int unsigned FRAME_WORDS_DEF = 9600;
  localparam int unsigned WCNT_W          = 14;
  localparam int unsigned FCNT_W          = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  // Packed word as seen by the two SDRAM write ports.
  typedef struct packed {
    logic [HALF_W-1:0] hi;
    logic [HALF_W-1:0] lo;
  } word_t;

endpackage

// File: rtl/binary_pixel_packer.sv
// Packs the 1-bit thresholded pixel stream into frame-aligned 32-bit words for the
// SDRAM write ports, with a per-frame word bound and optional partial-word flush.
module binary_pixel_packer
  import camera_pkg::*;
#(
  parameter int unsigned FRAME_WORDS   = FRAME_WORDS_DEF,
  parameter int unsigned FLUSH_PARTIAL = 1
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iEN,
  input  logic              iFVAL,
  input  logic              iDVAL,
  input  logic              iDATA,
  output logic [HALF_W-1:0] oDATA_LO,
  output logic [HALF_W-1:0] oDATA_HI,
  output logic              oWR,
  output logic [WCNT_W-1:0] oWORD_CNT,
  output logic [FCNT_W-1:0] oFRAME_CNT,
  output logic              oFRAME_DONE,
  output logic              oTRUNC,
  output logic              oBUSY
);

  localparam logic [WCNT_W-1:0] LIMIT    = WCNT_W'(FRAME_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PIX_PER_WORD - 1);
  localparam logic              FLUSH_EN = (FLUSH_PARTIAL != 0);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_fval_d;
  logic                      w_rise;
  logic                      w_fall;
  logic                      w_start;
  logic                      w_at_limit;
  logic [IDX_W-1:0]          r_idx;
  logic [IDX_W-1:0]          w_idx_nxt;
  logic [PIX_PER_WORD-1:0]   r_pack;
  logic [PIX_PER_WORD-1:0]   w_pack_nxt;
  logic [PIX_PER_WORD-1:0]   w_merged;
  word_t                     r_word;
  word_t                     w_word_nxt;
  logic                      r_wr;
  logic                      w_wr_nxt;
  logic [WCNT_W-1:0]         r_wcnt;
  logic [WCNT_W-1:0]         w_wcnt_nxt;
  logic [FCNT_W-1:0]         r_fcnt;
  logic [FCNT_W-1:0]         w_fcnt_nxt;
  logic                      r_done;
  logic                      w_done_nxt;
  logic                      r_trunc;
  logic                      w_trunc_nxt;
  logic                      r_busy;

  assign w_rise     = iFVAL & ~r_fval_d;
  assign w_fall     = ~iFVAL & r_fval_d;
  assign w_at_limit = (r_wcnt >= LIMIT);
  // New frame: enabled rise from IDLE, or a rise while ACTIVE (lost fall, resync).
  assign w_start    = w_rise & (((r_state == IDLE) & iEN) | (r_state == ACTIVE));

  always_comb begin
    w_merged        = r_pack;
    w_merged[r_idx] = iDATA;
  end

  // State register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_rise && iEN) w_state_nxt = ACTIVE;
      ACTIVE:  if (w_fall) w_state_nxt = FLUSH;
      FLUSH:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values; frame close work is done on the edge entering FLUSH.
  always_comb begin
    w_idx_nxt   = r_idx;
    w_pack_nxt  = r_pack;
    w_word_nxt  = r_word;
    w_wr_nxt    = 1'b0;
    w_wcnt_nxt  = r_wcnt;
    w_fcnt_nxt  = r_fcnt;
    w_done_nxt  = 1'b0;
    w_trunc_nxt = r_trunc;
    if (w_start) begin
      w_idx_nxt   = '0;
      w_pack_nxt  = '0;
      w_wcnt_nxt  = '0;
      w_trunc_nxt = 1'b0;
    end else if (r_state == ACTIVE) begin
      if (w_fall) begin
        if ((r_idx != '0) && FLUSH_EN && !w_at_limit) begin
          w_word_nxt = word_t'(r_pack);
          w_wr_nxt   = 1'b1;
          w_wcnt_nxt = r_wcnt + WCNT_W'(1);
        end
        w_done_nxt = 1'b1;
        w_fcnt_nxt = r_fcnt + FCNT_W'(1);
        w_idx_nxt  = '0;
        w_pack_nxt = '0;
      end else if (iDVAL && iFVAL) begin
        if (w_at_limit) begin
          w_trunc_nxt = 1'b1;
        end else if (r_idx == LAST_IDX) begin
          w_word_nxt = word_t'(w_merged);
          w_wr_nxt   = 1'b1;
          w_wcnt_nxt = r_wcnt + WCNT_W'(1);
          w_idx_nxt  = '0;
          w_pack_nxt = '0;
        end else begin
          w_idx_nxt  = r_idx + IDX_W'(1);
          w_pack_nxt = w_merged;
        end
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_fval_d <= 1'b0;
      r_idx    <= '0;
      r_pack   <= '0;
      r_word   <= '0;
      r_wr     <= 1'b0;
      r_wcnt   <= '0;
      r_fcnt   <= '0;
      r_done   <= 1'b0;
      r_trunc  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_fval_d <= iFVAL;
      r_idx    <= w_idx_nxt;
      r_pack   <= w_pack_nxt;
      r_word   <= w_word_nxt;
      r_wr     <= w_wr_nxt;
      r_wcnt   <= w_wcnt_nxt;
      r_fcnt   <= w_fcnt_nxt;
      r_done   <= w_done_nxt;
      r_trunc  <= w_trunc_nxt;
      r_busy   <= (w_state_nxt != IDLE);
    end
  end

  assign oDATA_LO    = r_word.lo;
  assign oDATA_HI    = r_word.hi;
  assign oWR         = r_wr;
  assign oWORD_CNT   = r_wcnt;
  assign oFRAME_CNT  = r_fcnt;
  assign oFRAME_DONE = r_done;
  assign oTRUNC      = r_trunc;
  assign oBUSY       = r_busy;

endmodule

// File: tb/tb_binary_pixel_packer.sv
// Scoreboard bench: three packer variants (default, no partial flush, 2-word frame bound)
// share one directed stimulus; a negedge monitor checks every write strobe.
module tb_binary_pixel_packer;

  typedef struct packed {
    logic [31:0] d;
    logic [13:0] wc;
    logic [31:0] st;
  } exp_t;

  typedef struct packed {
    logic [1:0]  inst;
    logic [15:0] trig;
    logic [31:0] d;
    logic [13:0] wc;
  } plan_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_en = 1'b0;
  logic        i_fval = 1'b0;
  logic        i_dval = 1'b0;
  logic        i_data = 1'b0;

  logic [15:0] lo   [3];
  logic [15:0] hi   [3];
  logic        wr   [3];
  logic [13:0] wcnt [3];
  logic [15:0] fcnt [3];
  logic        done [3];
  logic        trunc[3];
  logic        busy [3];

  exp_t  q0[$];
  exp_t  q1[$];
  exp_t  q2[$];
  plan_t plan[$];

  int n_chk  = 0;
  int n_pass = 0;
  int edge_n = 0;
  int dn[3]  = '{0, 0, 0};

  always #5 clk = ~clk;

  binary_pixel_packer u_def (
    .iCLK(clk), .iRST_N(rst_n), .iEN(i_en), .iFVAL(i_fval), .iDVAL(i_dval), .iDATA(i_data),
    .oDATA_LO(lo[0]), .oDATA_HI(hi[0]), .oWR(wr[0]), .oWORD_CNT(wcnt[0]),
    .oFRAME_CNT(fcnt[0]), .oFRAME_DONE(done[0]), .oTRUNC(trunc[0]), .oBUSY(busy[0])
  );

  binary_pixel_packer #(.FLUSH_PARTIAL(0)) u_nf (
    .iCLK(clk), .iRST_N(rst_n), .iEN(i_en), .iFVAL(i_fval), .iDVAL(i_dval), .iDATA(i_data),
    .oDATA_LO(lo[1]), .oDATA_HI(hi[1]), .oWR(wr[1]), .oWORD_CNT(wcnt[1]),
    .oFRAME_CNT(fcnt[1]), .oFRAME_DONE(done[1]), .oTRUNC(trunc[1]), .oBUSY(busy[1])
  );

  binary_pixel_packer #(.FRAME_WORDS(2)) u_fw2 (
    .iCLK(clk), .iRST_N(rst_n), .iEN(i_en), .iFVAL(i_fval), .iDVAL(i_dval), .iDATA(i_data),
    .oDATA_LO(lo[2]), .oDATA_HI(hi[2]), .oWR(wr[2]), .oWORD_CNT(wcnt[2]),
    .oFRAME_CNT(fcnt[2]), .oFRAME_DONE(done[2]), .oTRUNC(trunc[2]), .oBUSY(busy[2])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic push_exp(input int inst, input exp_t e);
    case (inst)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int inst);
    case (inst)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Monitor: every strobe must match the oldest expected word of its instance.
  task automatic check_wr(input int i);
    exp_t e;
    if (qsize(i) == 0) begin
      chk($sformatf("unexpected_wr[%0d]", i), 64'({hi[i], lo[i]}), 64'hDEAD_BEEF_0000_0000);
      return;
    end
    case (i)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    chk($sformatf("word[%0d]", i), 64'({hi[i], lo[i]}), 64'(e.d));
    chk($sformatf("wcnt_at_wr[%0d]", i), 64'(wcnt[i]), 64'(e.wc));
    chk($sformatf("wr_cycle[%0d]", i), 64'(edge_n), 64'(e.st));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (wr[i]) check_wr(i);
        if (done[i]) dn[i]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  // Release planned expectations whose trigger is pixel p (0 = FVAL fall).
  task automatic issue(input int p);
    exp_t e;
    foreach (plan[k]) begin
      if (int'(plan[k].trig) == p) begin
        e.d  = plan[k].d;
        e.wc = plan[k].wc;
        e.st = 32'(edge_n + 1);
        push_exp(int'(plan[k].inst), e);
      end
    end
  endtask

  task automatic expect_word(input int inst, input int trig, input logic [31:0] d,
                             input logic [13:0] wc);
    plan_t p;
    p.inst = 2'(inst);
    p.trig = 16'(trig);
    p.d    = d;
    p.wc   = wc;
    plan.push_back(p);
  endtask

  task automatic expect_all(input int trig, input logic [31:0] d, input logic [13:0] wc);
    for (int i = 0; i < 3; i++) expect_word(i, trig, d, wc);
  endtask

  task automatic run_frame(input bit en, input logic [127:0] bits, input int n,
                           input int gap, input bit do_fall);
    i_en = en; i_fval = 1'b1; i_dval = 1'b0; i_data = 1'b0;
    tick();
    for (int p = 1; p <= n; p++) begin
      i_dval = 1'b1;
      i_data = bits[p-1];
      issue(p);
      tick();
      for (int g = 0; g < gap; g++) begin
        i_dval = 1'b0;
        i_data = 1'($urandom_range(0, 1));
        tick();
      end
    end
    if (do_fall) begin
      // A valid pixel in the fall cycle must not be packed.
      i_fval = 1'b0; i_dval = 1'b1; i_data = 1'b1;
      issue(0);
      tick();
      i_dval = 1'b0; i_data = 1'b0;
      repeat (4) tick();
    end
  endtask

  task automatic end_checks(input string t, input int wc0, input int wc1, input int wc2,
                            input int fc, input int tr2, input int ed);
    int wc[3];
    wc = '{wc0, wc1, wc2};
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s.wcnt[%0d]", t, i), 64'(wcnt[i]), 64'(wc[i]));
      chk($sformatf("%s.fcnt[%0d]", t, i), 64'(fcnt[i]), 64'(fc));
      chk($sformatf("%s.trunc[%0d]", t, i), 64'(trunc[i]), (i == 2) ? 64'(tr2) : 64'(0));
      chk($sformatf("%s.busy[%0d]", t, i), 64'(busy[i]), 64'(0));
      chk($sformatf("%s.pending[%0d]", t, i), 64'(qsize(i)), 64'(0));
      chk($sformatf("%s.done_pulses[%0d]", t, i), 64'(dn[i]), 64'(ed));
    end
    plan.delete();
  endtask

  initial begin
    logic [127:0] alt;
    logic [127:0] ones;
    alt  = {32{4'h5}};
    ones = '1;

    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst.wr[%0d]", i), 64'(wr[i]), 64'(0));
      chk($sformatf("rst.data[%0d]", i), 64'({hi[i], lo[i]}), 64'(0));
      chk($sformatf("rst.fcnt[%0d]", i), 64'(fcnt[i]), 64'(0));
      chk($sformatf("rst.busy[%0d]", i), 64'(busy[i]), 64'(0));
    end
    rst_n = 1'b1;
    repeat (2) tick();

    // 64 alternating pixels -> two 0x55555555 words.
    expect_all(32, 32'h5555_5555, 14'd1);
    expect_all(64, 32'h5555_5555, 14'd2);
    run_frame(1'b1, alt, 64, 0, 1'b1);
    end_checks("alt64", 2, 2, 2, 1, 0, 1);

    // 40 ones -> full word plus 0xFF partial (not on the no-flush variant).
    expect_all(32, 32'hFFFF_FFFF, 14'd1);
    expect_word(0, 0, 32'h0000_00FF, 14'd2);
    expect_word(2, 0, 32'h0000_00FF, 14'd2);
    run_frame(1'b1, ones, 40, 0, 1'b1);
    end_checks("ones40", 2, 1, 2, 2, 0, 2);

    // 100 ones -> 3 words + 0xF partial; bounded variant stops at 2 and truncates.
    for (int k = 1; k <= 3; k++) begin
      expect_word(0, 32 * k, 32'hFFFF_FFFF, 14'(k));
      expect_word(1, 32 * k, 32'hFFFF_FFFF, 14'(k));
    end
    expect_word(0, 0, 32'h0000_000F, 14'd4);
    expect_word(2, 32, 32'hFFFF_FFFF, 14'd1);
    expect_word(2, 64, 32'hFFFF_FFFF, 14'd2);
    run_frame(1'b1, ones, 100, 0, 1'b1);
    end_checks("ones100", 4, 3, 2, 3, 1, 3);

    // Disabled at frame start: frame skipped entirely, truncation flag untouched.
    run_frame(1'b0, alt, 64, 0, 1'b1);
    end_checks("skipped", 4, 3, 2, 3, 1, 3);

    // DVAL gaps, one valid pixel every third cycle.
    expect_all(32, 32'hA5C3_0F96, 14'd1);
    run_frame(1'b1, 128'hA5C3_0F96, 32, 2, 1'b1);
    end_checks("gaps", 1, 1, 1, 4, 0, 4);

    // Reset 20 pixels into a frame, then a clean frame packs from bit 0.
    run_frame(1'b1, ones, 20, 0, 1'b0);
    chk("mid.busy", 64'(busy[0]), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("arst.data[%0d]", i), 64'({hi[i], lo[i]}), 64'(0));
      chk($sformatf("arst.fcnt[%0d]", i), 64'(fcnt[i]), 64'(0));
      chk($sformatf("arst.wcnt[%0d]", i), 64'(wcnt[i]), 64'(0));
      chk($sformatf("arst.busy[%0d]", i), 64'(busy[i]), 64'(0));
    end
    i_fval = 1'b0; i_dval = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    expect_all(32, 32'h1234_5678, 14'd1);
    run_frame(1'b1, 128'h1234_5678, 32, 0, 1'b1);
    end_checks("post_rst", 1, 1, 1, 1, 0, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
